// File: rtl/qspi_pkg.sv
// Shared QSPI definitions: lane modes, receive FSM encoding and word helpers.
package qspi_pkg;

  localparam logic [1:0] LANE_SINGLE = 2'd0;
  localparam logic [1:0] LANE_DUAL   = 2'd1;
  localparam logic [1:0] LANE_QUAD   = 2'd2;

  localparam int RX_CNT_W = 6;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_t;

  // Bits in a word of (word_bytes + 1) bytes: 8, 16, 24 or 32.
  function automatic logic [RX_CNT_W-1:0] word_bits(input logic [1:0] word_bytes);
    return {1'b0, word_bytes, 3'b000} + 6'd8;
  endfunction

  function automatic logic [31:0] rev_in_bytes(input logic [31:0] word);
    logic [31:0] res;
    res = 32'd0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        res[b*8+i] = word[b*8+7-i];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/qspi_rx_lane_mux.sv
// Picks the bits appended per sample strobe and the shift step for the latched lane mode.
module qspi_rx_lane_mux
  import qspi_pkg::*;
(
  input  logic [1:0] lanes,
  input  logic [3:0] dq,
  output logic [3:0] bits,
  output logic [2:0] step
);

  // Single mode (and the reserved code) samples MISO on IO1.
  always_comb begin
    bits = 4'd0;
    step = 3'd1;
    case (lanes)
      LANE_DUAL: begin
        bits = {2'b00, dq[1:0]};
        step = 3'd2;
      end
      LANE_QUAD: begin
        bits = dq;
        step = 3'd4;
      end
      default: begin
        bits = {3'b000, dq[1]};
        step = 3'd1;
      end
    endcase
  end

endmodule

// File: rtl/qspi_rx_shifter.sv
// QSPI receive shifter: assembles 1-4 byte words from 1/2/4 data lanes into a valid/ready register.
// Optional macro QSPI_RX_LSB_FIRST_EN adds io_lsb_first for per-byte LSB-first reception.
module qspi_rx_shifter
  import qspi_pkg::*;
#(
  parameter int MAX_BYTES = 4
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   io_start_signal,
  input  logic                   io_qspi_data_en,
  input  logic [1:0]             io_lanes,
  input  logic [1:0]             io_word_bytes,
  input  logic [3:0]             io_dq_in,
`ifdef QSPI_RX_LSB_FIRST_EN
  input  logic                   io_lsb_first,
`endif
  output logic [MAX_BYTES*8-1:0] io_rx_data,
  output logic                   io_rx_valid,
  input  logic                   io_rx_ready,
  output logic                   io_busy,
  output logic                   io_overrun
);

  localparam int DW = MAX_BYTES * 8;

  rx_state_t             state_r, state_s;
  logic [1:0]            lanes_r, bytes_r;
  logic [RX_CNT_W-1:0]   cnt_r;
  logic [DW-1:0]         shreg_r, shifted_s, load_word_s;
  logic                  pend_r;
  logic [DW-1:0]         pend_word_r;
  logic [DW-1:0]         rx_data_r;
  logic                  rx_valid_r, overrun_r;
  logic                  start_shift_s, strobe_s, complete_s;
  logic [3:0]            bits_s;
  logic [2:0]            step_s;

  qspi_rx_lane_mux u_lane_mux (
    .lanes (lanes_r),
    .dq    (io_dq_in),
    .bits  (bits_s),
    .step  (step_s)
  );

  assign shifted_s = (shreg_r << step_s) | {{(DW-4){1'b0}}, bits_s};

`ifdef QSPI_RX_LSB_FIRST_EN
  logic lsb_r;

  // Bit order option is frozen for the session like lanes and size.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      lsb_r <= 1'b0;
    end else if (start_shift_s) begin
      lsb_r <= io_lsb_first;
    end else begin
      lsb_r <= lsb_r;
    end
  end

  assign load_word_s = lsb_r ? rev_in_bytes(shifted_s) : shifted_s;
`else
  assign load_word_s = shifted_s;
`endif

  // FSM state register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state plus strobe qualification; a dropped start aborts before any strobe is used.
  always_comb begin
    state_s       = state_r;
    start_shift_s = 1'b0;
    strobe_s      = 1'b0;
    complete_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (io_start_signal) begin
          state_s       = ST_SHIFT;
          start_shift_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!io_start_signal) begin
          state_s = ST_IDLE;
        end else if (io_qspi_data_en) begin
          strobe_s   = 1'b1;
          complete_s = (cnt_r == {{(RX_CNT_W-3){1'b0}}, step_s});
        end else begin
          state_s = ST_SHIFT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Shift register, bit counter, latched configuration and completed-word staging.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      lanes_r     <= LANE_SINGLE;
      bytes_r     <= 2'd0;
      cnt_r       <= {RX_CNT_W{1'b0}};
      shreg_r     <= {DW{1'b0}};
      pend_r      <= 1'b0;
      pend_word_r <= {DW{1'b0}};
    end else begin
      pend_r <= complete_s;
      if (complete_s) begin
        pend_word_r <= load_word_s;
      end else begin
        pend_word_r <= pend_word_r;
      end
      if (start_shift_s) begin
        lanes_r <= io_lanes;
        bytes_r <= io_word_bytes;
        cnt_r   <= word_bits(io_word_bytes);
        shreg_r <= {DW{1'b0}};
      end else if (complete_s) begin
        cnt_r   <= word_bits(bytes_r);
        shreg_r <= {DW{1'b0}};
      end else if (strobe_s) begin
        cnt_r   <= cnt_r - {{(RX_CNT_W-3){1'b0}}, step_s};
        shreg_r <= shifted_s;
      end else begin
        cnt_r   <= cnt_r;
        shreg_r <= shreg_r;
      end
    end
  end

  // Output register: a staged word loads when free or consumed this cycle, else it is dropped.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_r  <= {DW{1'b0}};
      rx_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      if (pend_r && (!rx_valid_r || io_rx_ready)) begin
        rx_data_r  <= pend_word_r;
        rx_valid_r <= 1'b1;
      end else if (rx_valid_r && io_rx_ready) begin
        rx_valid_r <= 1'b0;
      end else begin
        rx_valid_r <= rx_valid_r;
      end
      if (pend_r && rx_valid_r && !io_rx_ready) begin
        overrun_r <= 1'b1;
      end else if (start_shift_s) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign io_rx_data  = rx_data_r;
  assign io_rx_valid = rx_valid_r;
  assign io_overrun  = overrun_r;
  assign io_busy     = (state_r == ST_SHIFT);

endmodule

// File: tb/tb_qspi_rx_shifter.sv
// Randomized scoreboard bench for qspi_rx_shifter; expected words come from a word-level model.
module tb_qspi_rx_shifter;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_start_signal = 1'b0;
  logic        io_qspi_data_en = 1'b0;
  logic [1:0]  io_lanes = 2'd0;
  logic [1:0]  io_word_bytes = 2'd0;
  logic [3:0]  io_dq_in = 4'd0;
  logic        io_lsb_first = 1'b0;
  logic [31:0] io_rx_data;
  logic        io_rx_valid;
  logic        io_rx_ready = 1'b1;
  logic        io_busy;
  logic        io_overrun;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;
  logic [1:0]  cur_lanes = 2'd0;
  logic [1:0]  cur_wb = 2'd0;
  logic        cur_lsb = 1'b0;

  qspi_rx_shifter #(.MAX_BYTES(4)) dut (
    .clock           (clock),
    .rst_n           (rst_n),
    .io_start_signal (io_start_signal),
    .io_qspi_data_en (io_qspi_data_en),
    .io_lanes        (io_lanes),
    .io_word_bytes   (io_word_bytes),
    .io_dq_in        (io_dq_in),
`ifdef QSPI_RX_LSB_FIRST_EN
    .io_lsb_first    (io_lsb_first),
`endif
    .io_rx_data      (io_rx_data),
    .io_rx_valid     (io_rx_valid),
    .io_rx_ready     (io_rx_ready),
    .io_busy         (io_busy),
    .io_overrun      (io_overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Word-level reference: received bits form the number MSB first; LSB-first mirrors each byte.
  function automatic logic [31:0] model_word(input logic [31:0] data, input logic [1:0] wb,
                                             input logic lsb);
    logic [63:0] m;
    logic [31:0] d, r;
    int nb;
    nb = 8 * (int'(wb) + 1);
    m = (64'd1 << nb) - 64'd1;
    d = data & m[31:0];
    if (!lsb) return d;
    r = 32'd0;
    for (int k = 0; k < nb; k++) r[(k / 8) * 8 + (7 - k % 8)] = d[k];
    return r;
  endfunction

  // Monitor: every handshake consumes one word, which must match the scoreboard head.
  always @(negedge clock) begin
    if (rst_n && io_rx_valid && io_rx_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_word: got %h expected no word", io_rx_data);
      end else begin
        exp_w = exp_q.pop_front();
        check("rx_word", io_rx_data, exp_w);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic strobe(input logic [3:0] dq);
    io_dq_in = dq;
    io_qspi_data_en = 1'b1;
    @(posedge clock);
    #1;
    io_qspi_data_en = 1'b0;
    io_dq_in = 4'($urandom);
  endtask

  // Starts a session; a strobe is offered during the IDLE cycle and must be ignored.
  task automatic begin_rx(input logic [1:0] l, input logic [1:0] wb, input logic lsb);
    io_lanes = l;
    io_word_bytes = wb;
    io_lsb_first = lsb;
    cur_lanes = l;
    cur_wb = wb;
`ifdef QSPI_RX_LSB_FIRST_EN
    cur_lsb = lsb;
`else
    cur_lsb = 1'b0;
`endif
    io_start_signal = 1'b1;
    io_qspi_data_en = 1'b1;
    io_dq_in = 4'($urandom);
    @(posedge clock);
    #1;
    io_qspi_data_en = 1'b0;
    io_lanes = 2'($urandom);
    io_word_bytes = 2'($urandom);
    io_lsb_first = 1'($urandom);
  endtask

  task automatic end_rx();
    io_start_signal = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [31:0] data, input int gap, input bit push);
    int step, nbits, n;
    logic [31:0] chunk;
    step = (cur_lanes == 2'd2) ? 4 : (cur_lanes == 2'd1) ? 2 : 1;
    nbits = 8 * (int'(cur_wb) + 1);
    n = nbits / step;
    if (push) exp_q.push_back(model_word(data, cur_wb, cur_lsb));
    for (int i = 0; i < n; i++) begin
      idle(gap);
      chunk = (data >> (nbits - step * (i + 1))) & ((32'd1 << step) - 32'd1);
      if (step == 4) strobe(chunk[3:0]);
      else if (step == 2) strobe({2'($urandom), chunk[1:0]});
      else strobe({2'($urandom), chunk[0], 1'($urandom)});
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("reset_data", io_rx_data, 32'd0);
    check("reset_valid", {31'd0, io_rx_valid}, 32'd0);
    check("reset_busy", {31'd0, io_busy}, 32'd0);
    check("reset_overrun", {31'd0, io_overrun}, 32'd0);
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Quad 4-byte word, strobes 3 cycles apart, one-cycle output latency
    begin_rx(2'd2, 2'd3, 1'b0);
    check("busy_shift", {31'd0, io_busy}, 32'd1);
    send_word(32'h12345678, 2, 1'b1);
    check("latency_valid_low", {31'd0, io_rx_valid}, 32'd0);
    idle(1);
    check("latency_valid_high", {31'd0, io_rx_valid}, 32'd1);
    check("quad_data", io_rx_data, 32'h12345678);
    check("quad_overrun", {31'd0, io_overrun}, 32'd0);
    end_rx();
    check("busy_idle", {31'd0, io_busy}, 32'd0);
    idle(3);

    // Single 1-byte A5
    begin_rx(2'd0, 2'd0, 1'b0);
    send_word(32'h000000A5, 1, 1'b1);
    idle(2);
    end_rx();
    idle(3);

    // Dual 2-byte streaming with ready low: second word dropped, overrun set
    io_rx_ready = 1'b0;
    begin_rx(2'd1, 2'd1, 1'b0);
    send_word(32'h0000BEEF, 0, 1'b1);
    send_word(32'h00001234, 1, 1'b0);
    idle(2);
    check("overrun_set", {31'd0, io_overrun}, 32'd1);
    check("overrun_valid", {31'd0, io_rx_valid}, 32'd1);
    end_rx();
    io_rx_ready = 1'b1;
    idle(3);
    check("overrun_sticky", {31'd0, io_overrun}, 32'd1);
    begin_rx(2'd2, 2'd0, 1'b0);
    check("overrun_cleared", {31'd0, io_overrun}, 32'd0);
    end_rx();
    idle(2);

    // Abort after 3 strobes, then a clean all-ones word
    begin_rx(2'd2, 2'd3, 1'b0);
    repeat (3) strobe(4'($urandom));
    end_rx();
    begin_rx(2'd2, 2'd3, 1'b0);
    send_word(32'hFFFFFFFF, 1, 1'b1);
    idle(3);
    end_rx();
    idle(2);

    // Completion on the same edge as a consume
    io_rx_ready = 1'b0;
    begin_rx(2'd2, 2'd0, 1'b0);
    send_word(32'h0000005A, 0, 1'b1);
    idle(2);
    send_word(32'h000000C3, 0, 1'b1);
    io_rx_ready = 1'b1;
    idle(1);
    check("simul_valid", {31'd0, io_rx_valid}, 32'd1);
    check("simul_overrun", {31'd0, io_overrun}, 32'd0);
    idle(2);
    end_rx();
    idle(2);

    // Asynchronous reset mid-word with valid and overrun set
    io_rx_ready = 1'b0;
    begin_rx(2'd2, 2'd0, 1'b0);
    send_word(32'h0000003C, 0, 1'b0);
    idle(1);
    send_word(32'h00000011, 0, 1'b0);
    idle(2);
    strobe(4'h7);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_data", io_rx_data, 32'd0);
    check("arst_valid", {31'd0, io_rx_valid}, 32'd0);
    check("arst_overrun", {31'd0, io_overrun}, 32'd0);
    check("arst_busy", {31'd0, io_busy}, 32'd0);
    io_start_signal = 1'b0;
    io_rx_ready = 1'b1;
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    idle(2);

`ifdef QSPI_RX_LSB_FIRST_EN
    // LSB-first single byte 01 reads back as 80
    begin_rx(2'd0, 2'd0, 1'b1);
    send_word(32'h00000001, 1, 1'b1);
    idle(3);
    end_rx();
    idle(2);
`endif

    // Randomized sessions, including the reserved lane code
    for (int s = 0; s < 25; s++) begin
      begin_rx(2'($urandom_range(0, 3)), 2'($urandom), 1'($urandom));
      check("rand_busy", {31'd0, io_busy}, 32'd1);
      for (int w = 0; w < int'($urandom_range(1, 3)); w++)
        send_word($urandom, int'($urandom_range(0, 2)), 1'b1);
      idle(2);
      end_rx();
      check("rand_overrun", {31'd0, io_overrun}, 32'd0);
    end

    for (int t = 0; t < 100 && exp_q.size() != 0; t++) idle(1);
    check("drain", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
